// File: rtl/mult_seq_ctrl_if.sv
// Operand/result handshake bundle for mult_seq_ctrl.
//   in_valid, a, b : operand pair offered by the source
//   in_ready       : controller can accept an operand pair
//   out_valid, y   : completed product held for the consumer
//   out_ready      : consumer takes y
//   busy           : controller is running or holding a result
// Modports: slave = the controller, master = the source/consumer side.
interface mult_seq_ctrl_if #(
   parameter int unsigned WIDTH = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   y;
   logic                 busy;

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, y, busy
   );

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, y, busy
   );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for a WIDTH x WIDTH unsigned shift-add multiplier.
// Accepts an operand pair, then adds one partial-product slice
// (a_slice * b) << offset per clock, consuming BITS_PER_CYCLE bits of a
// LSB first. The 2*WIDTH-bit product is held on y with out_valid until taken.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mult_seq_ctrl_if slave (in_valid/in_ready/a/b,
//         out_valid/out_ready/y, busy)
module mult_seq_ctrl #(
   parameter int unsigned WIDTH          = 16,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic           clk,
   input  logic           rst,
   mult_seq_ctrl_if.slave bus
);

   localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned PW = 2 * WIDTH;

   if (BITS_PER_CYCLE == 0 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
      $error("mult_seq_ctrl: BITS_PER_CYCLE must divide WIDTH");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t                    state_q;
   logic [CW-1:0]             count_q;
   logic [WIDTH-1:0]          a_q;
   logic [WIDTH-1:0]          b_q;
   logic [PW-1:0]             acc_q;
   logic [PW-1:0]             y_q;
   logic                      out_valid_q;
   logic                      in_ready_q;
   logic                      busy_q;

   logic [31:0]               offset;
   logic [BITS_PER_CYCLE-1:0] slice;
   logic [PW-1:0]             term;
   logic [PW-1:0]             acc_next;
   logic                      last;

   // Slice product is zero-extended to the full product width before shifting,
   // so no bits are lost for the top slices.
   always_comb begin
      offset   = 32'(count_q) * BITS_PER_CYCLE;
      slice    = a_q[offset +: BITS_PER_CYCLE];
      term     = (PW'(slice) * PW'(b_q)) << offset;
      acc_next = acc_q + term;
      last     = (count_q == CW'(N - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         count_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         y_q         <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               // in_ready is registered, so it first rises one edge after reset.
               in_ready_q <= 1'b1;
               if (bus.in_valid && in_ready_q) begin
                  a_q        <= bus.a;
                  b_q        <= bus.b;
                  acc_q      <= '0;
                  count_q    <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= StRun;
               end
            end
            StRun: begin
               acc_q   <= acc_next;
               count_q <= count_q + CW'(1);
               if (last) begin
                  y_q         <= acc_next;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               // No accept in the handshake cycle: in_ready only rises here.
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: a 1-bit-per-cycle instance and a
// 4-bits-per-cycle instance, directed table vectors, hand sequences for
// backpressure / reset abort / back-to-back accept, and random operands
// checked against a plain a*b reference with a fixed latency of N.
module tb_mult_seq_ctrl;

   logic clk;
   logic rst;

   int   checks;
   int   errors;
   int   lat;
   logic seen;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] y;
   } vec_t;

   vec_t vecs[6];

   mult_seq_ctrl_if #(.WIDTH(16)) if1 ();
   mult_seq_ctrl_if #(.WIDTH(16)) if4 ();

   mult_seq_ctrl #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   mult_seq_ctrl #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (if4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ready1(input string tag);
      int n;
      n = 0;
      while (!if1.in_ready && n < 40) begin
         step();
         n++;
      end
      check({tag, " in_ready"}, if1.in_ready, 1);
   endtask

   // One full operation on the 1-bit instance with `stall` cycles of held-off out_ready.
   task automatic op1(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                      input int stall, input string tag);
      int l;
      wait_ready1(tag);
      if1.a = a;
      if1.b = b;
      if1.in_valid = 1'b1;
      if1.out_ready = 1'b0;
      step();
      if1.in_valid = 1'b0;
      if1.a = 16'($urandom);
      if1.b = 16'($urandom);
      check({tag, " busy"}, if1.busy, 1);
      l = 0;
      while (!if1.out_valid && l < 64) begin
         step();
         if1.a = 16'($urandom);
         l++;
      end
      check({tag, " latency"}, l, 16);
      check({tag, " y"}, if1.y, exp);
      check({tag, " in_ready in done"}, if1.in_ready, 0);
      for (int i = 0; i < stall; i++) begin
         if1.in_valid = 1'($urandom);
         if1.a = 16'($urandom);
         if1.b = 16'($urandom);
         step();
         check({tag, " hold y"}, if1.y, exp);
         check({tag, " hold out_valid"}, if1.out_valid, 1);
         check({tag, " hold in_ready"}, if1.in_ready, 0);
      end
      if1.in_valid = 1'b0;
      if1.out_ready = 1'b1;
      step();
      if1.out_ready = 1'b0;
      check({tag, " out_valid after take"}, if1.out_valid, 0);
      check({tag, " in_ready after take"}, if1.in_ready, 1);
      check({tag, " busy after take"}, if1.busy, 0);
      check({tag, " y kept"}, if1.y, exp);
   endtask

   task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                      input string tag);
      int l;
      l = 0;
      while (!if4.in_ready && l < 40) begin
         step();
         l++;
      end
      check({tag, " in_ready"}, if4.in_ready, 1);
      if4.a = a;
      if4.b = b;
      if4.in_valid = 1'b1;
      if4.out_ready = 1'b0;
      step();
      if4.in_valid = 1'b0;
      if4.a = 16'($urandom);
      l = 0;
      while (!if4.out_valid && l < 64) begin
         step();
         l++;
      end
      check({tag, " latency"}, l, 4);
      check({tag, " y"}, if4.y, exp);
      if4.out_ready = 1'b1;
      step();
      if4.out_ready = 1'b0;
      check({tag, " out_valid after take"}, if4.out_valid, 0);
      check({tag, " in_ready after take"}, if4.in_ready, 1);
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      checks = 0;
      errors = 0;

      vecs[0] = '{a: 16'd3,    b: 16'd5,    y: 32'd15};
      vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, y: 32'hFFFE0001};
      vecs[2] = '{a: 16'h0000, b: 16'h1234, y: 32'h00000000};
      vecs[3] = '{a: 16'h1234, b: 16'h0010, y: 32'h00012340};
      vecs[4] = '{a: 16'h0001, b: 16'hFFFF, y: 32'h0000FFFF};
      vecs[5] = '{a: 16'h8000, b: 16'h8000, y: 32'h40000000};

      rst = 1'b1;
      if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.out_ready = 1'b0;
      if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.out_ready = 1'b0;

      // Reset state
      #12;
      check("reset in_ready", if1.in_ready, 0);
      check("reset out_valid", if1.out_valid, 0);
      check("reset y", if1.y, 0);
      check("reset busy", if1.busy, 0);
      check("reset in_ready bpc4", if4.in_ready, 0);
      rst = 1'b0;
      #1;
      check("in_ready before first edge", if1.in_ready, 0);
      step();
      check("in_ready after first edge", if1.in_ready, 1);

      // Directed table
      for (int i = 0; i < 6; i++) begin
         op1(vecs[i].a, vecs[i].b, vecs[i].y, 0, $sformatf("vec%0d", i));
      end

      // Backpressure with input churn in DONE
      op1(16'd1000, 16'd3, 32'd3000, 5, "backpressure");

      // Reset aborts a run at count=7
      wait_ready1("abort");
      if1.a = 16'hBEEF;
      if1.b = 16'h0101;
      if1.in_valid = 1'b1;
      step();
      if1.in_valid = 1'b0;
      for (int i = 0; i < 7; i++) step();
      rst = 1'b1;
      #2;
      check("abort out_valid in reset", if1.out_valid, 0);
      check("abort busy in reset", if1.busy, 0);
      check("abort y in reset", if1.y, 0);
      #2;
      rst = 1'b0;
      step();
      check("abort in_ready after reset", if1.in_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (if1.out_valid) seen = 1'b1;
      end
      check("abort no out_valid", seen, 0);
      op1(16'h1234, 16'h0010, 32'h00012340, 0, "after abort");

      // BITS_PER_CYCLE=4 instance
      op4(16'hABCD, 16'h1234, 32'h0C374FA4, "bpc4 ABCD");

      // Back-to-back accepts with in_valid held high
      wait_ready1("queue");
      if1.a = 16'd7;
      if1.b = 16'd9;
      if1.in_valid = 1'b1;
      if1.out_ready = 1'b1;
      step();
      if1.a = 16'd100;
      if1.b = 16'd200;
      lat = 0;
      while (!if1.out_valid && lat < 64) begin
         step();
         lat++;
      end
      check("queue first latency", lat, 16);
      check("queue first y", if1.y, 63);
      step();
      check("queue handshake out_valid", if1.out_valid, 0);
      check("queue no accept in handshake", if1.in_ready, 1);
      check("queue y after handshake", if1.y, 63);
      step();
      if1.in_valid = 1'b0;
      check("queue second accepted", if1.in_ready, 0);
      check("queue second busy", if1.busy, 1);
      lat = 0;
      while (!if1.out_valid && lat < 64) begin
         step();
         lat++;
      end
      check("queue second latency", lat, 16);
      check("queue second y", if1.y, 20000);
      step();
      if1.out_ready = 1'b0;
      check("queue second taken", if1.out_valid, 0);

      // Random operands against a*b
      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 7 == 3) ra = 16'hFFFF;
         if (i % 9 == 4) rb = 16'h0000;
         op1(ra, rb, 32'(ra) * 32'(rb), int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
      end
      for (int i = 0; i < 10; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         op4(ra, rb, 32'(ra) * 32'(rb), $sformatf("rand4_%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
